// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the memory stage: FSM states, register-index
// width and the layout of the M->W pipeline register.
package pipeline_pkg;

    localparam int REG_ADDR_WIDTH = 5;

    // Default datapath widths used for the reference record layout below.
    localparam int MW_ADDR_WIDTH = 32;
    localparam int MW_DATA_WIDTH = 32;

    // IDLE: no request outstanding. REQ/WAIT: a request has been presented.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    // M->W record. The top packs its register in this same field order,
    // with the datapath fields sized by its own parameters.
    typedef struct packed {
        logic                      valid;
        logic                      reg_write;
        logic                      result_src;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [MW_DATA_WIDTH-1:0]  alu_result;
        logic [MW_DATA_WIDTH-1:0]  read_data;
        logic [MW_ADDR_WIDTH-1:0]  pc_plus4;
    } mw_fields_t;

endpackage

// File: rtl/flip_flop4.sv
// M->W pipeline register. A load captures everything; a bubble clears only
// the control bits (valid, reg_write) and leaves the data fields untouched.
module flip_flop4 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             bubble,
    input  logic [1:0]       ctrl_d,
    input  logic [WIDTH-1:0] data_d,
    output logic [1:0]       ctrl_q,
    output logic [WIDTH-1:0] data_q
);

    // Load wins over bubble; a bubble kills the instruction but holds data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else if (load) begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end else if (bubble) begin
            ctrl_q <= '0;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: drives the data-memory request/response
// handshake, stalls upstream while a load/store is outstanding, aborts on
// timeout, and feeds the M->W pipeline register.
module mem_stage_ctrl
    import pipeline_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      validM_i,
    input  logic [DATA_WIDTH-1:0]     alu_resultM_i,
    input  logic [DATA_WIDTH-1:0]     write_dataM_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdM_i,
    input  logic [ADDRESS_WIDTH-1:0]  pc_plus4M_i,
    input  logic                      reg_writeM_i,
    input  logic                      result_srcM_i,
    input  logic                      mem_writeM_i,
    output logic                      dmem_req_o,
    output logic                      dmem_we_o,
    output logic [ADDRESS_WIDTH-1:0]  dmem_addr_o,
    output logic [DATA_WIDTH-1:0]     dmem_wdata_o,
    input  logic                      dmem_gnt_i,
    input  logic                      dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata_i,
    output logic                      stall_o,
    output logic                      validW_o,
    output logic                      reg_writeW_o,
    output logic                      result_srcW_o,
    output logic [DATA_WIDTH-1:0]     alu_resultW_o,
    output logic [DATA_WIDTH-1:0]     read_dataW_o,
    output logic [REG_ADDR_WIDTH-1:0] rdW_o,
    output logic [ADDRESS_WIDTH-1:0]  pc_plus4W_o,
    output logic                      err_o
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    // Last permitted cycle in REQ+WAIT: the counter starts at 0 on entry.
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam int                W_DATA_W = 1 + REG_ADDR_WIDTH + 2 * DATA_WIDTH + ADDRESS_WIDTH;

    mem_state_t             state, state_next;
    logic [CNT_W-1:0]       cnt;
    logic                   mem_op, is_store, is_load, timed_out;
    logic                   req, stall, complete, abort;
    logic [DATA_WIDTH-1:0]  w_rdata;
    logic [ADDRESS_WIDTH-1:0] addr_src;
    logic [1:0]             w_ctrl_q;
    logic [W_DATA_W-1:0]    w_data_q;

    // Load+store together behaves as a store.
    assign mem_op    = validM_i & (result_srcM_i | mem_writeM_i);
    assign is_store  = mem_writeM_i;
    assign is_load   = result_srcM_i & ~mem_writeM_i;
    assign timed_out = (state != IDLE) && (cnt == CNT_LAST);

    // The memory address is the ALU result, fitted to the address width.
    generate
        if (ADDRESS_WIDTH <= DATA_WIDTH) begin : g_addr_trunc
            assign addr_src = alu_resultM_i[ADDRESS_WIDTH-1:0];
        end else begin : g_addr_ext
            assign addr_src = {{(ADDRESS_WIDTH - DATA_WIDTH){1'b0}}, alu_resultM_i};
        end
    endgenerate

    // Next state, handshake and stall. Nothing is requested while in reset.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        stall      = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        w_rdata    = '0;
        if (!rst_i) begin
            case (state)
                IDLE, REQ: begin
                    if (!mem_op) begin
                        complete   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        req = 1'b1;
                        if (is_store && dmem_gnt_i) begin
                            complete   = 1'b1;
                            state_next = IDLE;
                        end else if (is_load && dmem_gnt_i && dmem_rvalid_i) begin
                            complete   = 1'b1;
                            w_rdata    = dmem_rdata_i;
                            state_next = IDLE;
                        end else if (timed_out) begin
                            abort      = 1'b1;
                            state_next = IDLE;
                        end else if (dmem_gnt_i) begin
                            stall      = 1'b1;
                            state_next = WAIT;
                        end else begin
                            // rvalid without a grant is ignored here
                            stall      = 1'b1;
                            state_next = REQ;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid_i) begin
                        complete   = 1'b1;
                        w_rdata    = dmem_rdata_i;
                        state_next = IDLE;
                    end else if (timed_out) begin
                        abort      = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign stall_o      = stall;
    assign dmem_req_o   = req;
    assign dmem_we_o    = req & mem_writeM_i;
    assign dmem_addr_o  = req ? addr_src : '0;
    assign dmem_wdata_o = (req & mem_writeM_i) ? write_dataM_i : '0;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    // Timeout counter: zero on entry to REQ/WAIT, counts while there.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                   cnt <= '0;
        else if (state == IDLE || state_next == IDLE) cnt <= '0;
        else                                         cnt <= cnt + CNT_W'(1);
    end

    // Sticky timeout flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      err_o <= 1'b0;
        else if (abort) err_o <= 1'b1;
    end

    flip_flop4 #(
        .WIDTH (W_DATA_W)
    ) u_mw_reg (
        .clk    (clk_i),
        .rst    (rst_i),
        .load   (complete),
        .bubble (stall | abort),
        .ctrl_d ({validM_i, reg_writeM_i}),
        .data_d ({result_srcM_i, rdM_i, alu_resultM_i, w_rdata, pc_plus4M_i}),
        .ctrl_q (w_ctrl_q),
        .data_q (w_data_q)
    );

    assign {validW_o, reg_writeW_o} = w_ctrl_q;
    assign {result_srcW_o, rdW_o, alu_resultW_o, read_dataW_o, pc_plus4W_o} = w_data_q;

endmodule
